// File: rtl/mux_stream_arb.sv
// N-channel valid/ready stream multiplexer with a single registered output stage.
// Channel choice comes from an explicit select (mode=0) or round-robin arbitration (mode=1).
module mux_stream_arb #(
  parameter  int WIDTH = 2,
  parameter  int NCH   = 4,
  localparam int SELW  = $clog2(NCH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NCH*WIDTH-1:0] in_data,
  input  logic [NCH-1:0]       in_valid,
  output logic [NCH-1:0]       in_ready,
  input  logic                 mode,
  input  logic [SELW-1:0]      sel,
  output logic [WIDTH-1:0]     out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [SELW-1:0]      out_ch
);

  logic [WIDTH-1:0] ch_data [NCH];

  genvar gi;
  generate
    for (gi = 0; gi < NCH; gi++) begin : g_unpack
      assign ch_data[gi] = in_data[gi*WIDTH +: WIDTH];
    end
  endgenerate

  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic             out_valid_q, out_valid_d;
  logic [SELW-1:0]  out_ch_q, out_ch_d;
  logic [SELW-1:0]  rr_ptr_q, rr_ptr_d;

  logic             grant_vld;
  logic [SELW-1:0]  grant;
  logic [SELW-1:0]  rr_idx;
  logic             slot_free;
  logic             xfer;

  assign slot_free = !out_valid_q || out_ready;

  // Round-robin scans rr_ptr+1 .. rr_ptr+NCH (wrapping), first valid wins.
  always_comb begin
    grant_vld = 1'b0;
    grant     = '0;
    rr_idx    = '0;
    if (!mode) begin
      if (int'(sel) < NCH) begin
        grant_vld = 1'b1;
        grant     = sel;
      end
    end else begin
      for (int off = 1; off <= NCH; off++) begin
        rr_idx = SELW'((int'(rr_ptr_q) + off) % NCH);
        if (!grant_vld && in_valid[rr_idx]) begin
          grant_vld = 1'b1;
          grant     = rr_idx;
        end
      end
    end
  end

  // Ready is masked while reset is asserted so upstream sees no acceptance.
  always_comb begin
    in_ready = '0;
    if (rst_n && grant_vld) begin
      in_ready[grant] = slot_free;
    end
  end

  assign xfer = grant_vld && in_valid[grant] && slot_free;

  always_comb begin
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    out_ch_d    = out_ch_q;
    rr_ptr_d    = rr_ptr_q;
    if (xfer) begin
      out_data_d  = ch_data[grant];
      out_ch_d    = grant;
      out_valid_d = 1'b1;
      if (mode) begin
        rr_ptr_d = grant;
      end
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_ch_q    <= '0;
      rr_ptr_q    <= SELW'(NCH - 1);
    end else begin
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_ch_q    <= out_ch_d;
      rr_ptr_q    <= rr_ptr_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign out_ch    = out_ch_q;

endmodule

// File: tb/tb_mux_stream_arb.sv
// Directed bench for mux_stream_arb: a 4-channel instance for most scenarios and
// a 5-channel instance to reach an out-of-range select.
module tb_mux_stream_arb;

  logic       clk = 1'b0;
  logic       rst_n;

  logic [7:0] in_data;
  logic [3:0] in_valid;
  logic [3:0] in_ready;
  logic       mode;
  logic [1:0] sel;
  logic [1:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic [1:0] out_ch;

  logic [9:0] in_data5;
  logic [4:0] in_valid5;
  logic [4:0] in_ready5;
  logic       mode5;
  logic [2:0] sel5;
  logic [1:0] out_data5;
  logic       out_valid5;
  logic       out_ready5;
  logic [2:0] out_ch5;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  always #5 clk = ~clk;

  mux_stream_arb #(.WIDTH(2), .NCH(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .mode(mode), .sel(sel), .out_data(out_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_ch(out_ch)
  );

  mux_stream_arb #(.WIDTH(2), .NCH(5)) dut5 (
    .clk(clk), .rst_n(rst_n), .in_data(in_data5), .in_valid(in_valid5),
    .in_ready(in_ready5), .mode(mode5), .sel(sel5), .out_data(out_data5),
    .out_valid(out_valid5), .out_ready(out_ready5), .out_ch(out_ch5)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    $display("cyc %0d: out_valid=%0d out_ch=%0d out_data=%0d in_ready=%b | dut5 out_valid=%0d out_ch=%0d",
             cyc, out_valid, out_ch, out_data, in_ready, out_valid5, out_ch5);
  endtask

  initial begin
    rst_n      = 1'b0;
    in_data    = {2'd0, 2'd1, 2'd2, 2'd3};
    in_valid   = 4'h0;
    mode       = 1'b0;
    sel        = 2'd0;
    out_ready  = 1'b1;
    in_data5   = {2'd2, 2'd1, 2'd0, 2'd3, 2'd1};
    in_valid5  = 5'h00;
    mode5      = 1'b0;
    sel5       = 3'd0;
    out_ready5 = 1'b1;

    #1;
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_out_data", 32'(out_data), 0);
    check("rst_out_ch", 32'(out_ch), 0);
    check("rst_in_ready", 32'(in_ready), 0);
    step();
    step();
    rst_n = 1'b1;

    // Fixed select: ch0..3 carry 3,2,1,0.
    in_valid = 4'hF;
    #1;
    check("fix_in_ready0", 32'(in_ready), 32'h1);
    for (int i = 0; i < 4; i++) begin
      step();
      check("fix_out_valid", 32'(out_valid), 1);
      check("fix_out_ch", 32'(out_ch), 32'(i));
      check("fix_out_data", 32'(out_data), 32'(3 - i));
      sel = 2'(i + 1);
    end
    in_valid = 4'h0;
    step();
    check("fix_drain_valid", 32'(out_valid), 0);
    check("fix_drain_hold_ch", 32'(out_ch), 3);

    // Round-robin with all channels valid starts at ch0.
    mode     = 1'b1;
    in_valid = 4'hF;
    for (int i = 0; i < 6; i++) begin
      step();
      check("rr_all_ch", 32'(out_ch), 32'(i % 4));
      check("rr_all_data", 32'(out_data), 32'(3 - (i % 4)));
    end

    // Reset mid-stream with a word held.
    check("pre_rst_valid", 32'(out_valid), 1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 32'(out_valid), 0);
    check("mid_rst_data", 32'(out_data), 0);
    check("mid_rst_ch", 32'(out_ch), 0);
    check("mid_rst_in_ready", 32'(in_ready), 0);
    step();
    rst_n = 1'b1;

    // Only ch1 and ch3 valid after reset.
    in_valid = 4'b1010;
    for (int i = 0; i < 4; i++) begin
      step();
      check("rr_odd_ch", 32'(out_ch), (i % 2 == 0) ? 1 : 3);
      check("rr_odd_valid", 32'(out_valid), 1);
    end

    // Backpressure on the held ch3 word (data 0).
    out_ready = 1'b0;
    #1;
    check("bp_in_ready", 32'(in_ready), 0);
    for (int i = 0; i < 3; i++) begin
      step();
      check("bp_valid", 32'(out_valid), 1);
      check("bp_ch", 32'(out_ch), 3);
      check("bp_data", 32'(out_data), 0);
      check("bp_in_ready_hold", 32'(in_ready), 0);
    end
    out_ready = 1'b1;
    #1;
    check("bp_release_ready", 32'(in_ready), 32'b0010);
    step();
    check("bp_release_valid", 32'(out_valid), 1);
    check("bp_release_ch", 32'(out_ch), 1);
    check("bp_release_data", 32'(out_data), 2);

    // Mode switch: RR grants ch2, fixed sel=0 gives ch0, back to RR gives ch3.
    in_valid = 4'hF;
    step();
    check("ms_rr_ch", 32'(out_ch), 2);
    mode = 1'b0;
    sel  = 2'd0;
    step();
    check("ms_fix_ch", 32'(out_ch), 0);
    check("ms_fix_data", 32'(out_data), 3);
    mode = 1'b1;
    step();
    check("ms_rr_back_ch", 32'(out_ch), 3);
    check("ms_rr_back_data", 32'(out_data), 0);

    // Out-of-range select on the 5-channel instance.
    in_valid5 = 5'h1F;
    sel5      = 3'd4;
    #1;
    check("n5_in_ready_sel4", 32'(in_ready5), 32'b10000);
    step();
    check("n5_valid", 32'(out_valid5), 1);
    check("n5_ch", 32'(out_ch5), 4);
    check("n5_data", 32'(out_data5), 2);
    sel5 = 3'd6;
    #1;
    check("n5_bad_sel_ready", 32'(in_ready5), 0);
    step();
    check("n5_bad_sel_drain", 32'(out_valid5), 0);
    check("n5_bad_sel_hold_ch", 32'(out_ch5), 4);
    step();
    check("n5_bad_sel_idle", 32'(out_valid5), 0);
    check("n5_bad_sel_ready2", 32'(in_ready5), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
